// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS run controller: states, command
// opcodes, halt reasons and default sizing.
package mips_ctrl_pkg;

  localparam int unsigned IMEM_DEPTH_DEF = 64;
  localparam int unsigned ADDR_W_DEF     = 6;
  localparam int unsigned CNT_W_DEF      = 32;
  localparam int unsigned RST_CYCLES_DEF = 2;
  localparam int unsigned DATA_W         = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_CORE,
    ST_RUN,
    ST_STEP,
    ST_DONE
  } state_e;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  localparam logic [1:0] HALT_NONE      = 2'b00;
  localparam logic [1:0] HALT_LIMIT     = 2'b01;
  localparam logic [1:0] HALT_SELF_LOOP = 2'b10;
  localparam logic [1:0] HALT_STOP      = 2'b11;

  // States in which the core clock enable is high.
  function automatic logic core_en_state(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/mips_run_controller_if.sv
// Host command channel, core control/observe and status bundle of the
// MIPS run controller; slave = controller side, master = host/core side.
interface mips_run_controller_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [31:0]       cmd_data;
  logic [31:0]       pc_in;
  logic              core_reset;
  logic              core_en;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic [1:0]        halt_reason;
  logic [CNT_W-1:0]  cycle_count;
  logic              cmd_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, pc_in,
    output cmd_ready, core_reset, core_en, imem_we, imem_addr, imem_wdata,
           busy, done, halt_reason, cycle_count, cmd_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, pc_in,
    input  cmd_ready, core_reset, core_en, imem_we, imem_addr, imem_wdata,
           busy, done, halt_reason, cycle_count, cmd_err
  );
endinterface

// File: rtl/mips_run_counter.sv
// Enabled-cycle counter with saturation, run-limit compare and PC self-loop
// detection for the MIPS run controller.
module mips_run_counter
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] limit,
  input  logic             count_en,
  input  logic             track_pc,
  input  logic             pc_clr,
  input  logic [31:0]      pc_in,
  output logic [CNT_W-1:0] cycle_count,
  output logic             limit_hit_c,
  output logic             self_loop_c
);

  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [31:0]      pc_prev_q, pc_prev_d;
  logic             pc_valid_q, pc_valid_d;

  always_comb begin
    cycle_count_d = cycle_count_q;
    limit_d       = limit_q;
    pc_prev_d     = pc_prev_q;
    pc_valid_d    = pc_valid_q;

    if (start) begin
      cycle_count_d = '0;
      limit_d       = limit;
    end else if (count_en && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end

    if (pc_clr) begin
      pc_valid_d = 1'b0;
    end else if (track_pc) begin
      pc_prev_d  = pc_in;
      pc_valid_d = 1'b1;
    end
  end

  // Evaluated during the current enabled cycle, before its increment lands.
  assign limit_hit_c = (limit_q != '0) && ((cycle_count_q + CNT_W'(1)) == limit_q);
  assign self_loop_c = pc_valid_q && (pc_in == pc_prev_q);
  assign cycle_count = cycle_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count_q <= '0;
      limit_q       <= '0;
      pc_prev_q     <= '0;
      pc_valid_q    <= 1'b0;
    end else begin
      cycle_count_q <= cycle_count_d;
      limit_q       <= limit_d;
      pc_prev_q     <= pc_prev_d;
      pc_valid_q    <= pc_valid_d;
    end
  end

endmodule

// File: rtl/mips_run_controller.sv
// Life-cycle sequencer for the single-cycle MIPS core: IMEM loading, core
// reset pulse, bounded/self-loop-terminated runs and single-stepping.
module mips_run_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  mips_run_controller_if.slave bus
);

  localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic [1:0]        halt_reason_q, halt_reason_d;
  logic              cmd_err_q, cmd_err_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              core_reset_q, core_reset_d;
  logic              core_en_q, core_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept_c;
  logic              run_start_c;
  logic              limit_hit_c;
  logic              self_loop_c;
  logic [CNT_W-1:0]  cycle_count;

  assign accept_c = bus.cmd_valid && cmd_ready_q;

  mips_run_counter #(.CNT_W(CNT_W)) u_counter (
    .clock       (clock),
    .reset       (reset),
    .start       (run_start_c),
    .limit       (CNT_W'(bus.cmd_data)),
    .count_en    (core_en_state(state_q)),
    .track_pc    (state_q == ST_RUN),
    .pc_clr      (state_q == ST_RESET_CORE),
    .pc_in       (bus.pc_in),
    .cycle_count (cycle_count),
    .limit_hit_c (limit_hit_c),
    .self_loop_c (self_loop_c)
  );

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    load_ptr_d    = load_ptr_q;
    imem_we_d     = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;
    halt_reason_d = halt_reason_q;
    cmd_err_d     = 1'b0;
    run_start_c   = 1'b0;

    // The IMEM write and RUN start are shared by IDLE and DONE.
    if (accept_c && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
      if (bus.cmd_op == OP_LOAD) begin
        imem_we_d    = 1'b1;
        imem_addr_d  = load_ptr_q;
        imem_wdata_d = bus.cmd_data;
        load_ptr_d   = (load_ptr_q == ADDR_W'(IMEM_DEPTH - 1)) ? '0
                                                                : load_ptr_q + ADDR_W'(1);
      end else if (bus.cmd_op == OP_RUN) begin
        run_start_c   = 1'b1;
        halt_reason_d = HALT_NONE;
        rst_cnt_d     = '0;
        state_d       = ST_RESET_CORE;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_c && (bus.cmd_op == OP_STOP)) load_ptr_d = '0;
        if (accept_c && (bus.cmd_op == OP_STEP)) cmd_err_d  = 1'b1;
      end
      ST_RESET_CORE: begin
        if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) state_d   = ST_RUN;
        else                                      rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
      ST_RUN: begin
        if (accept_c && (bus.cmd_op == OP_STOP)) begin
          halt_reason_d = HALT_STOP;
          state_d       = ST_DONE;
        end else if (self_loop_c) begin
          halt_reason_d = HALT_SELF_LOOP;
          state_d       = ST_DONE;
        end else if (limit_hit_c) begin
          halt_reason_d = HALT_LIMIT;
          state_d       = ST_DONE;
        end
        if (accept_c && ((bus.cmd_op == OP_LOAD) || (bus.cmd_op == OP_STEP))) cmd_err_d = 1'b1;
      end
      ST_STEP: state_d = ST_DONE;
      ST_DONE: begin
        if (accept_c) begin
          if (bus.cmd_op == OP_STEP) state_d = ST_STEP;
          if ((bus.cmd_op == OP_LOAD) || (bus.cmd_op == OP_STOP)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the next-state decode.
    cmd_ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_DONE);
    core_reset_d = (state_d == ST_IDLE) || (state_d == ST_RESET_CORE);
    core_en_d    = core_en_state(state_d);
    busy_d       = (state_d == ST_RESET_CORE) || core_en_state(state_d);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rst_cnt_q     <= '0;
      load_ptr_q    <= '0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      halt_reason_q <= HALT_NONE;
      cmd_err_q     <= 1'b0;
      cmd_ready_q   <= 1'b1;
      core_reset_q  <= 1'b1;
      core_en_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      load_ptr_q    <= load_ptr_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      halt_reason_q <= halt_reason_d;
      cmd_err_q     <= cmd_err_d;
      cmd_ready_q   <= cmd_ready_d;
      core_reset_q  <= core_reset_d;
      core_en_q     <= core_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.core_reset  = core_reset_q;
  assign bus.core_en     = core_en_q;
  assign bus.imem_we     = imem_we_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.imem_wdata  = imem_wdata_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.halt_reason = halt_reason_q;
  assign bus.cycle_count = cycle_count;
  assign bus.cmd_err     = cmd_err_q;

endmodule
